// File: rtl/unidade_busca.sv
// Instruction fetch stage: PC register, IF/ID register and a three-state
// fetch FSM with branch redirect, stall, end-of-program and error handling.
module unidade_busca #(
  parameter int END_INICIAL = 0,
  parameter int ULTIMO_END  = 21
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Parar,
  input  logic        DesvioTomado,
  input  logic [31:0] EnderecoDesvio,
  input  logic [31:0] Instrucao,
  output logic [31:0] EnderecoAtual,
  output logic [31:0] InstrucaoID,
  output logic [31:0] PC_ID,
  output logic        ValidoID,
  output logic        Terminado,
  output logic        ErroEndereco,
  output logic [31:0] ContadorBuscas
);

  typedef enum logic [1:0] {
    INICIO,
    BUSCA,
    FIM
  } estado_t;

  localparam logic [31:0] PC_RST = 32'(END_INICIAL);
  localparam logic [31:0] PC_MAX = 32'(ULTIMO_END);

  estado_t     estado_q, estado_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] cnt_q, cnt_d;
  logic        valido_q, valido_d;
  logic        erro_q, erro_d;

  logic alvo_ok;
  logic br_ok;
  logic br_err;
  logic segura;
  logic avanca;

  // One-hot decode of the cycle's action; branch outranks stall.
  assign alvo_ok = EnderecoDesvio <= PC_MAX;
  assign br_ok   = DesvioTomado & alvo_ok;
  assign br_err  = DesvioTomado & ~alvo_ok;
  assign segura  = ~DesvioTomado & Parar;
  assign avanca  = ~DesvioTomado & ~Parar;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      estado_q <= INICIO;
      pc_q     <= PC_RST;
      instr_q  <= '0;
      pc_id_q  <= '0;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_id_q  <= pc_id_d;
      valido_q <= valido_d;
      erro_q   <= erro_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      INICIO: estado_d = BUSCA;
      BUSCA: begin
        if (br_ok) estado_d = BUSCA;
        else if (br_err) estado_d = FIM;
        else if (avanca && pc_q == PC_MAX) estado_d = FIM;
      end
      FIM: begin
        if (br_ok) estado_d = BUSCA;
      end
      default: estado_d = INICIO;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_id_d  = pc_id_q;
    valido_d = valido_q;
    erro_d   = erro_q;
    cnt_d    = cnt_q;
    if (estado_q != INICIO) begin
      unique case (1'b1)
        br_ok: begin
          pc_d     = EnderecoDesvio;
          instr_d  = '0;
          valido_d = 1'b0;
        end
        br_err: begin
          erro_d   = 1'b1;
          valido_d = 1'b0;
        end
        segura: begin
          valido_d = valido_q;
        end
        avanca: begin
          if (estado_q == BUSCA) begin
            instr_d  = Instrucao;
            pc_id_d  = pc_q;
            valido_d = 1'b1;
            cnt_d    = cnt_q + 32'd1;
            if (pc_q != PC_MAX) pc_d = pc_q + 32'd1;
          end else begin
            valido_d = 1'b0;
          end
        end
        default: valido_d = valido_q;
      endcase
    end
  end

  assign EnderecoAtual  = pc_q;
  assign InstrucaoID    = instr_q;
  assign PC_ID          = pc_id_q;
  assign ValidoID       = valido_q;
  assign ErroEndereco   = erro_q;
  assign ContadorBuscas = cnt_q;
  assign Terminado      = estado_q == FIM;

endmodule

// File: doc/unidade_busca.md
UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports CLK and RST_N.
REQ-002 The block SHALL have parameter END_INICIAL, default 0, the word address fetched first after reset.
REQ-003 The block SHALL have parameter ULTIMO_END, default 21, the last valid instruction-ROM word address.
REQ-004 The block SHALL have the following ports.
- CLK  in  1  clock, all state on posedge.
- RST_N  in  1  asynchronous active-low reset.
- Parar  in  1  stall request from decode/hazard logic.
- DesvioTomado  in  1  branch taken, sampled on posedge.
- EnderecoDesvio  in  32  branch target word address.
- Instrucao  in  32  instruction-memory output for EnderecoAtual; the memory updates it on negedge, so it is valid at the following posedge.
- EnderecoAtual  out  32  current PC, drives the instruction-memory address.
- InstrucaoID  out  32  IF/ID register: instruction.
- PC_ID  out  32  IF/ID register: address of InstrucaoID.
- ValidoID  out  1  IF/ID register holds a real instruction.
- Terminado  out  1  high while in state FIM.
- ErroEndereco  out  1  sticky, set by an out-of-range branch target.
- ContadorBuscas  out  32  count of instructions delivered with ValidoID=1.

Function
REQ-005 The FSM SHALL have exactly three states: INICIO, BUSCA and FIM.
REQ-006 INICIO SHALL last exactly one cycle, capture nothing, ignore Parar and DesvioTomado, and go to BUSCA.
REQ-007 In BUSCA with Parar=0 and DesvioTomado=0, each posedge SHALL apply all of the following.
- InstrucaoID<=Instrucao.
- PC_ID<=EnderecoAtual.
- ValidoID<=1.
- ContadorBuscas<=ContadorBuscas+1, wrapping mod 2^32.
- EnderecoAtual<=EnderecoAtual+1 (word addressing).
REQ-008 In BUSCA with Parar=1 and DesvioTomado=0, all registers SHALL hold.
REQ-009 DesvioTomado=1 SHALL take priority over Parar in BUSCA and FIM.
REQ-010 A taken branch with EnderecoDesvio<=ULTIMO_END SHALL apply all of the following.
- EnderecoAtual<=EnderecoDesvio.
- ValidoID<=0 and InstrucaoID<=0 (flush).
- ContadorBuscas unchanged.
- Next state BUSCA.
REQ-011 A taken branch with EnderecoDesvio>ULTIMO_END SHALL apply all of the following.
- ErroEndereco<=1.
- ValidoID<=0.
- EnderecoAtual unchanged.
- Next state FIM.
REQ-012 When a normal capture (REQ-007) occurs with EnderecoAtual==ULTIMO_END, the capture SHALL proceed, EnderecoAtual SHALL hold, and the next state SHALL be FIM.
REQ-013 In FIM without a branch, EnderecoAtual SHALL hold, ValidoID<=0 at the next posedge with Parar=0, and ValidoID SHALL hold while Parar=1.
REQ-014 A valid branch in FIM (REQ-010) SHALL return to BUSCA; ErroEndereco SHALL remain set once set.
REQ-015 Terminado SHALL be combinational (state==FIM).
REQ-016 Fetch latency SHALL be one cycle: the instruction at address A appears on InstrucaoID with ValidoID=1 one posedge after the cycle EnderecoAtual==A without stall or branch.
REQ-017 EnderecoAtual SHALL never exceed ULTIMO_END.

Reset
REQ-018 RST_N=0 SHALL immediately, asynchronously, force all of the following.
- State INICIO.
- EnderecoAtual=END_INICIAL.
- InstrucaoID=0, PC_ID=0, ValidoID=0.
- ErroEndereco=0, ContadorBuscas=0, Terminado=0.
REQ-019 Reset asserted mid-operation (any state, including during a stall or branch) SHALL discard all in-flight state identically to REQ-018.

Verification
REQ-020 After reset release, memory returning word 32'h1000_0000+addr, no stall -> cycle 1 ValidoID=0; then InstrucaoID=32'h1000_0000, 32'h1000_0001... with PC_ID=0,1,...
REQ-021 Parar=1 for 3 cycles while EnderecoAtual=5 -> EnderecoAtual, InstrucaoID, PC_ID, ValidoID and ContadorBuscas frozen 3 cycles; then fetch resumes at 5.
REQ-022 DesvioTomado=1 with Parar=1 and EnderecoDesvio=12 at EnderecoAtual=7 -> next cycle EnderecoAtual=12 and ValidoID=0; the following cycle PC_ID=12 and ValidoID=1.
REQ-023 Run to address 21 -> PC_ID=21 with ValidoID=1, Terminado=1, EnderecoAtual stays 21, next cycle ValidoID=0, ContadorBuscas=22.
REQ-024 DesvioTomado=1 with EnderecoDesvio=40 -> ErroEndereco=1, Terminado=1, EnderecoAtual unchanged; a later branch to 3 -> BUSCA at 3 with ErroEndereco still 1.
REQ-025 RST_N pulsed low between posedges mid-run at EnderecoAtual=9 -> outputs reset immediately without waiting for a clock edge, then REQ-020 behaviour repeats.
